// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Purpose : Shared definitions for the TPU systolic-array processing elements.
//           Default operand / partial-sum widths and the per-operation
//           arithmetic mode used by every PE in the array.
// Contents: TPU_ACT_W, TPU_WGT_W, TPU_PSUM_W  default widths
//           pe_mode_e                         PE_UNSIGNED / PE_SIGNED
// ---------------------------------------------------------------------------
package tpu_pkg;

    localparam int TPU_ACT_W  = 8;
    localparam int TPU_WGT_W  = 8;
    localparam int TPU_PSUM_W = 32;

    // Encoding matches the raw signed_mode pin so a plain cast converts it.
    typedef enum logic {
        PE_UNSIGNED = 1'b0,
        PE_SIGNED   = 1'b1
    } pe_mode_e;

endpackage

// File: rtl/pe_mul_ext.sv
// ---------------------------------------------------------------------------
// pe_mul_ext
// Purpose : Stage-1 multiplier of the weight-stationary PE. Registers
//           i_act * i_wgt and extends the (ACT_W+WGT_W)-bit product to
//           PSUM_W bits, sign-extending in PE_SIGNED mode and zero-extending
//           in PE_UNSIGNED mode.
// Ports   : clk     in  clock, rising edge
//           rst_n   in  synchronous active-low reset
//           i_en    in  load a new product this cycle
//           i_act   in  [ACT_W]  activation operand
//           i_wgt   in  [WGT_W]  weight operand
//           i_mode  in  pe_mode_e operand interpretation
//           o_prod  out [PSUM_W] registered, extended product
// ---------------------------------------------------------------------------
module pe_mul_ext
    import tpu_pkg::*;
#(
    parameter int ACT_W  = TPU_ACT_W,
    parameter int WGT_W  = TPU_WGT_W,
    parameter int PSUM_W = TPU_PSUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [ACT_W-1:0]  i_act,
    input  logic [WGT_W-1:0]  i_wgt,
    input  pe_mode_e          i_mode,
    output logic [PSUM_W-1:0] o_prod
);

    localparam int PROD_W = ACT_W + WGT_W;

    logic              w_isSigned;
    logic [PROD_W-1:0] w_actExt;
    logic [PROD_W-1:0] w_wgtExt;
    logic [PROD_W-1:0] w_prod;
    logic [PSUM_W-1:0] w_prodExt;
    logic [PSUM_W-1:0] r_prod;

    assign w_isSigned = (i_mode == PE_SIGNED);

    // Extending both operands to the full product width and keeping the low
    // PROD_W bits of the product gives the exact result for both modes, so a
    // single unsigned multiplier serves signed and unsigned operations.
    assign w_actExt = {{WGT_W{w_isSigned & i_act[ACT_W-1]}}, i_act};
    assign w_wgtExt = {{ACT_W{w_isSigned & i_wgt[WGT_W-1]}}, i_wgt};
    assign w_prod   = w_actExt * w_wgtExt;

    // Widen the product to the partial-sum width according to the op's mode.
    always_comb begin
        w_prodExt = PSUM_W'(w_prod);
        if (w_isSigned) begin
            w_prodExt = PSUM_W'($signed(w_prod));
        end
    end

    // Product register; only loads for valid operations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prod <= '0;
        end else if (i_en) begin
            r_prod <= w_prodExt;
        end
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/pe_ws_dbuf.sv
// ---------------------------------------------------------------------------
// pe_ws_dbuf
// Purpose : Weight-stationary MAC processing element with a double-buffered
//           weight. A shadow weight is filled through a daisy chain
//           (wgt_in -> shadow -> wgt_out) and copied into the active weight
//           by wgt_swap in one cycle. Two-stage valid-qualified pipeline:
//           stage 1 multiplies, stage 2 adds the incoming partial sum.
//           The arithmetic mode (signed/unsigned) travels with each op.
// Config  : `define PE_SATURATE_EN to clamp overflowing stage-2 results per
//           the op's mode and raise the sticky ovf flag (cleared by
//           ovf_clr, set wins). Without it sums wrap and ovf is tied 0.
// Ports   : clk, rst_n                    clock / sync active-low reset
//           wgt_shift_en, wgt_in, wgt_out weight chain (shadow register)
//           wgt_swap                      shadow -> active copy
//           act_valid_in, act_in, psum_in, signed_mode   operation input
//           act_valid_out, act_out        activation forwarded (latency 1)
//           psum_valid_out, psum_out      psum_in + act*weight (latency 2)
//           ovf, ovf_clr                  sticky saturation flag and clear
// ---------------------------------------------------------------------------
module pe_ws_dbuf
    import tpu_pkg::*;
#(
    parameter int ACT_W  = TPU_ACT_W,
    parameter int WGT_W  = TPU_WGT_W,
    parameter int PSUM_W = TPU_PSUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wgt_shift_en,
    input  logic [WGT_W-1:0]  wgt_in,
    output logic [WGT_W-1:0]  wgt_out,
    input  logic              wgt_swap,
    input  logic              act_valid_in,
    input  logic [ACT_W-1:0]  act_in,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              signed_mode,
    output logic              act_valid_out,
    output logic [ACT_W-1:0]  act_out,
    output logic              psum_valid_out,
    output logic [PSUM_W-1:0] psum_out,
    output logic              ovf,
    input  logic              ovf_clr
);

    if (PSUM_W < ACT_W + WGT_W) begin : g_badWidth
        $error("pe_ws_dbuf: PSUM_W must be >= ACT_W + WGT_W");
    end

    pe_mode_e          w_mode;
    logic [WGT_W-1:0]  r_shadowWgt;
    logic [WGT_W-1:0]  r_activeWgt;
    logic [ACT_W-1:0]  r_actOut;
    logic              r_actValidOut;
    logic [PSUM_W-1:0] r_psumS1;
    pe_mode_e          r_modeS1;
    logic              r_validS1;
    logic [PSUM_W-1:0] w_prodS1;
    logic [PSUM_W-1:0] w_result;
    logic [PSUM_W-1:0] r_psumOut;
    logic              r_psumValidOut;

    assign w_mode = pe_mode_e'(signed_mode);

    // Weight double buffer. A swap copies the pre-edge shadow, so shifting
    // and swapping in the same cycle moves the old shadow into the active
    // register while the chain keeps advancing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadowWgt <= '0;
            r_activeWgt <= '0;
        end else begin
            if (wgt_shift_en) begin
                r_shadowWgt <= wgt_in;
            end
            if (wgt_swap) begin
                r_activeWgt <= r_shadowWgt;
            end
        end
    end

    // Stage 1: the multiplier samples the active weight as it stood before
    // this edge; psum and mode are carried alongside so the op is
    // self-contained when it reaches stage 2.
    pe_mul_ext #(
        .ACT_W  (ACT_W),
        .WGT_W  (WGT_W),
        .PSUM_W (PSUM_W)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (act_valid_in),
        .i_act  (act_in),
        .i_wgt  (r_activeWgt),
        .i_mode (w_mode),
        .o_prod (w_prodS1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_psumS1      <= '0;
            r_modeS1      <= PE_UNSIGNED;
            r_validS1     <= 1'b0;
            r_actOut      <= '0;
            r_actValidOut <= 1'b0;
        end else begin
            r_validS1     <= act_valid_in;
            r_actValidOut <= act_valid_in;
            if (act_valid_in) begin
                r_psumS1 <= psum_in;
                r_modeS1 <= w_mode;
                r_actOut <= act_in;
            end
        end
    end

`ifdef PE_SATURATE_EN
    logic [PSUM_W:0] w_sum;
    logic            w_clamp;
    logic            r_ovf;

    // Widened add: the extra bit is the unsigned carry-out. Signed overflow
    // shows up as two same-signed operands producing a differently-signed sum.
    assign w_sum = {1'b0, r_psumS1} + {1'b0, w_prodS1};

    always_comb begin
        w_result = w_sum[PSUM_W-1:0];
        w_clamp  = 1'b0;
        if (r_modeS1 == PE_SIGNED) begin
            if ((r_psumS1[PSUM_W-1] == w_prodS1[PSUM_W-1]) &&
                (w_sum[PSUM_W-1] != r_psumS1[PSUM_W-1])) begin
                w_clamp  = 1'b1;
                w_result = r_psumS1[PSUM_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}}
                                              : {1'b0, {(PSUM_W-1){1'b1}}};
            end
        end else if (w_sum[PSUM_W]) begin
            w_clamp  = 1'b1;
            w_result = '1;
        end
    end

    // Sticky overflow: a clamp in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_validS1 && w_clamp) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unusedOvfClr;

    assign w_result       = r_psumS1 + w_prodS1;
    assign ovf            = 1'b0;
    assign w_unusedOvfClr = ovf_clr;
`endif

    // Stage 2: psum_out holds across bubbles; only the valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_psumOut      <= '0;
            r_psumValidOut <= 1'b0;
        end else begin
            r_psumValidOut <= r_validS1;
            if (r_validS1) begin
                r_psumOut <= w_result;
            end
        end
    end

    assign wgt_out        = r_shadowWgt;
    assign act_out        = r_actOut;
    assign act_valid_out  = r_actValidOut;
    assign psum_out       = r_psumOut;
    assign psum_valid_out = r_psumValidOut;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// ---------------------------------------------------------------------------
// tb_pe_ws_dbuf
// Scoreboard bench for pe_ws_dbuf. The stimulus process computes each op's
// result with plain integer arithmetic and queues it with the cycle it is due;
// an independent monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pe_ws_dbuf;

    localparam int ACT_W  = 8;
    localparam int WGT_W  = 8;
    localparam int PSUM_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wgt_shift_en;
    logic [WGT_W-1:0]  wgt_in;
    logic [WGT_W-1:0]  wgt_out;
    logic              wgt_swap;
    logic              act_valid_in;
    logic [ACT_W-1:0]  act_in;
    logic [PSUM_W-1:0] psum_in;
    logic              signed_mode;
    logic              act_valid_out;
    logic [ACT_W-1:0]  act_out;
    logic              psum_valid_out;
    logic [PSUM_W-1:0] psum_out;
    logic              ovf;
    logic              ovf_clr;

    always #5 clk = ~clk;

    pe_ws_dbuf #(
        .ACT_W  (ACT_W),
        .WGT_W  (WGT_W),
        .PSUM_W (PSUM_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wgt_shift_en   (wgt_shift_en),
        .wgt_in         (wgt_in),
        .wgt_out        (wgt_out),
        .wgt_swap       (wgt_swap),
        .act_valid_in   (act_valid_in),
        .act_in         (act_in),
        .psum_in        (psum_in),
        .signed_mode    (signed_mode),
        .act_valid_out  (act_valid_out),
        .act_out        (act_out),
        .psum_valid_out (psum_valid_out),
        .psum_out       (psum_out),
        .ovf            (ovf),
        .ovf_clr        (ovf_clr)
    );

    typedef struct {
        int          due;
        logic [31:0] val;
        bit          sat;
    } exp_t;

    exp_t        actQ[$];
    exp_t        psumQ[$];
    int          cyc     = 0;
    int          rstCyc  = -1;
    int          clrCyc  = -1;
    int          errors  = 0;
    int          checks  = 0;
    bit          monEn   = 1'b0;
    logic [7:0]  modelShadow = '0;
    logic [7:0]  modelActive = '0;
    logic [7:0]  lastAct  = '0;
    logic [31:0] lastPsum = '0;
    bit          expOvf   = 1'b0;

    // Reference arithmetic: exact integer result, then wrap or clamp.
    function automatic void refOp(input logic [7:0] a, input logic [7:0] w,
                                  input logic [31:0] p, input bit sgn,
                                  output logic [31:0] r, output bit sat);
        longint prod;
        longint full;
        if (sgn) begin
            prod = longint'($signed(a)) * longint'($signed(w));
            full = longint'($signed(p)) + prod;
        end else begin
            prod = longint'(a) * longint'(w);
            full = longint'(p) + prod;
        end
        r   = full[31:0];
        sat = 1'b0;
`ifdef PE_SATURATE_EN
        if (sgn) begin
            if (full > 64'sd2147483647) begin
                r = 32'h7FFFFFFF; sat = 1'b1;
            end else if (full < -64'sd2147483648) begin
                r = 32'h80000000; sat = 1'b1;
            end
        end else if (full > 64'sd4294967295) begin
            r = 32'hFFFFFFFF; sat = 1'b1;
        end
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, actual, expected);
        end
    endtask

    // Drives one clock cycle of inputs and advances the model across the edge.
    task automatic applyStimulus(input bit rstn, input bit valid,
                                 input logic [7:0] act, input logic [31:0] psum,
                                 input bit sgn, input bit shift,
                                 input logic [7:0] win, input bit swap,
                                 input bit clr);
        exp_t        ea;
        exp_t        ep;
        logic [31:0] r;
        bit          sat;
        logic [7:0]  nShadow;
        logic [7:0]  nActive;
        rst_n        = rstn;
        act_valid_in = valid;
        act_in       = act;
        psum_in      = psum;
        signed_mode  = sgn;
        wgt_shift_en = shift;
        wgt_in       = win;
        wgt_swap     = swap;
        ovf_clr      = clr;
        if (!rstn) begin
            rstCyc  = cyc + 1;
            nShadow = '0;
            nActive = '0;
        end else begin
            nShadow = shift ? win : modelShadow;
            nActive = swap ? modelShadow : modelActive;
            if (clr) clrCyc = cyc + 1;
            if (valid) begin
                refOp(act, modelActive, psum, sgn, r, sat);
                ea.due = cyc + 1; ea.val = {24'b0, act}; ea.sat = 1'b0;
                ep.due = cyc + 2; ep.val = r;            ep.sat = sat;
                actQ.push_back(ea);
                psumQ.push_back(ep);
            end
        end
        @(posedge clk);
        cyc++;
        modelShadow = nShadow;
        modelActive = nActive;
        if (!rstn) begin
            actQ.delete();
            psumQ.delete();
            monEn = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h0, 32'h0, 0, 0, 8'h0, 0, 0);
    endtask

    task automatic loadWeight(input logic [7:0] w);
        applyStimulus(1, 0, 8'h0, 32'h0, 0, 1, w, 0, 0);
        applyStimulus(1, 0, 8'h0, 32'h0, 0, 0, 8'h0, 1, 0);
    endtask

    // Monitor: compares every output each cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        bit   setNow;
        if (monEn) begin
            if (cyc == rstCyc) begin
                checkOutput("reset_outputs",
                            {13'b0, act_valid_out, psum_valid_out, ovf, act_out, wgt_out, psum_out},
                            64'h0);
                lastAct  = '0;
                lastPsum = '0;
                expOvf   = 1'b0;
            end else begin
                setNow = 1'b0;
                if (actQ.size() > 0 && actQ[0].due == cyc) begin
                    e = actQ.pop_front();
                    checkOutput("act_valid", act_valid_out, 1);
                    checkOutput("act_out", act_out, e.val);
                    lastAct = e.val[7:0];
                end else begin
                    checkOutput("act_valid_idle", act_valid_out, 0);
                    checkOutput("act_hold", act_out, lastAct);
                end
                if (psumQ.size() > 0 && psumQ[0].due == cyc) begin
                    e = psumQ.pop_front();
                    checkOutput("psum_valid", psum_valid_out, 1);
                    checkOutput("psum_out", psum_out, e.val);
                    lastPsum = e.val;
                    setNow   = e.sat;
                end else begin
                    checkOutput("psum_valid_idle", psum_valid_out, 0);
                    checkOutput("psum_hold", psum_out, lastPsum);
                end
                if (setNow) expOvf = 1'b1;
                else if (clrCyc == cyc) expOvf = 1'b0;
                checkOutput("wgt_out", wgt_out, modelShadow);
                checkOutput("ovf", ovf, expOvf);
            end
        end
    end

    initial begin
        logic [31:0] p;
        // Reset
        applyStimulus(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 0, 0);
        applyStimulus(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 0, 0);
        // Basic op, w=5, act=10 -> 50
        loadWeight(8'd5);
        applyStimulus(1, 1, 8'd10, 32'd0, 0, 0, 8'h0, 0, 0);
        idle(3);
        // Back-to-back, then a one-cycle gap
        applyStimulus(1, 1, 8'd10, 32'd0, 0, 0, 8'h0, 0, 0);
        applyStimulus(1, 1, 8'd3, 32'd32, 0, 0, 8'h0, 0, 0);
        idle(1);
        applyStimulus(1, 1, 8'd4, 32'd1, 0, 0, 8'h0, 0, 0);
        idle(3);
        // Signed vs unsigned on the same bits
        loadWeight(8'hFD);
        applyStimulus(1, 1, 8'hFC, 32'hFFFFFFEC, 1, 0, 8'h0, 0, 0);
        applyStimulus(1, 1, 8'hFC, 32'hFFFFFFEC, 0, 0, 8'h0, 0, 0);
        idle(2);
        applyStimulus(1, 0, 8'h0, 32'h0, 0, 0, 8'h0, 0, 1);
        idle(2);
        // Swap timing: active=2, shadow=7, swap at the middle op
        loadWeight(8'd2);
        applyStimulus(1, 0, 8'h0, 32'h0, 0, 1, 8'd7, 0, 0);
        applyStimulus(1, 1, 8'd1, 32'd0, 0, 0, 8'h0, 0, 0);
        applyStimulus(1, 1, 8'd1, 32'd0, 0, 0, 8'h0, 1, 0);
        applyStimulus(1, 1, 8'd1, 32'd0, 0, 0, 8'h0, 0, 0);
        idle(3);
        // Signed positive overflow, then clear
        loadWeight(8'd127);
        applyStimulus(1, 1, 8'd1, 32'h7FFFFFF0, 1, 0, 8'h0, 0, 0);
        idle(3);
        applyStimulus(1, 0, 8'h0, 32'h0, 0, 0, 8'h0, 0, 1);
        idle(2);
        // Reset with ops in flight, then an op sees w=0
        applyStimulus(1, 1, 8'd9, 32'd100, 0, 0, 8'h0, 0, 0);
        applyStimulus(1, 1, 8'd8, 32'd200, 0, 0, 8'h0, 0, 0);
        applyStimulus(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 0, 0);
        applyStimulus(1, 1, 8'd5, 32'd1, 0, 0, 8'h0, 0, 0);
        idle(3);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(5))
                0:       p = 32'h7FFFFF00 + $urandom_range(255);
                1:       p = 32'hFFFFFF00 + $urandom_range(255);
                2:       p = 32'h80000000 + $urandom_range(255);
                default: p = $urandom;
            endcase
            applyStimulus(($urandom_range(99) != 0),
                          ($urandom_range(3) != 0),
                          8'($urandom), p,
                          1'($urandom_range(1)),
                          ($urandom_range(3) == 0),
                          8'($urandom),
                          ($urandom_range(5) == 0),
                          ($urandom_range(19) == 0));
        end
        idle(4);
        checkOutput("queues_drained", 64'(actQ.size() + psumQ.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
